// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key expansion sequencer: accepts a cipher key, runs seven
// expansion steps (one per clock), stores the fifteen round keys and
// serves them to the cipher datapath on a read port.
// The first key byte sits in the top bits of key_i (key_i[255:248]).
module aes256_key_sched_ctrl #(
    parameter bit read_reg_p = 1'b1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         key_v_i,
    input  logic [255:0] key_i,
    output logic         key_ready_o,
    output logic         busy_o,
    output logic         keys_valid_o,
    input  logic [3:0]   rk_addr_i,
    output logic [127:0] rk_o,
    output logic         rk_v_o
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t         state_q, state_d;
    logic [255:0]   work_q, work_d;
    logic [2:0]     rnd_q, rnd_d;
    logic [127:0]   rf_q [15];
    logic [255:0]   stepKey;
    logic           accept;
    logic           rdValid;
    logic [127:0]   rdData;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // One AES-256 expansion step: the next eight words from the current eight.
    function automatic logic [255:0] roundKey(input logic [255:0] k, input logic [3:0] r);
        logic [31:0] w [8];
        logic [31:0] n [8];
        logic [31:0] rcon;
        for (int i = 0; i < 8; i++) begin
            w[i] = k[255 - 32 * i -: 32];
        end
        rcon = 32'h0100_0000 << (r - 4'd1);
        n[0] = w[0] ^ subWord({w[7][23:0], w[7][31:24]}) ^ rcon;
        n[1] = w[1] ^ n[0];
        n[2] = w[2] ^ n[1];
        n[3] = w[3] ^ n[2];
        n[4] = w[4] ^ subWord(n[3]);
        n[5] = w[5] ^ n[4];
        n[6] = w[6] ^ n[5];
        n[7] = w[7] ^ n[6];
        return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
    endfunction

    assign key_ready_o  = (state_q != EXPAND);
    assign busy_o       = (state_q == EXPAND);
    assign keys_valid_o = (state_q == DONE);
    assign accept       = key_v_i & key_ready_o;

    // Sequencer next state: load on accept, step the working key in EXPAND.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rnd_d   = rnd_q;
        stepKey = roundKey(work_q, {1'b0, rnd_q});
        case (state_q)
            IDLE, DONE: begin
                if (key_v_i) begin
                    work_d  = key_i;
                    rnd_d   = 3'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                work_d = stepKey;
                if (rnd_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rnd_q   <= rnd_d;
        end
    end

    // Round-key file writes; the last step's upper half has no slot and is dropped.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rf_q[0] <= key_i[255:128];
            rf_q[1] <= key_i[127:0];
        end else if (state_q == EXPAND) begin
            rf_q[{rnd_q, 1'b0}] <= stepKey[255:128];
            if (rnd_q != 3'd7) begin
                rf_q[{rnd_q, 1'b1}] <= stepKey[127:0];
            end
        end
    end

    assign rdValid = keys_valid_o && (rk_addr_i != 4'd15);
    assign rdData  = rdValid ? rf_q[rk_addr_i] : '0;

    generate
        if (read_reg_p) begin : g_reg_read
            logic [127:0] rk_q;
            logic         rk_v_q;

            // Registered read port: data follows the address by one cycle.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    rk_q   <= '0;
                    rk_v_q <= 1'b0;
                end else begin
                    rk_q   <= rdData;
                    rk_v_q <= rdValid;
                end
            end

            assign rk_o   = rk_q;
            assign rk_v_o = rk_v_q;
        end else begin : g_comb_read
            assign rk_o   = rdData;
            assign rk_v_o = rdValid;
        end
    endgenerate

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Self-checking bench for aes256_key_sched_ctrl: a registered-read and a
// combinational-read instance share stimulus and are checked against a
// word-level AES-256 key expansion model with an arithmetically built S-box.
module tb_aes256_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         keyV = 1'b0;
    logic [255:0] keyData = '0;
    logic [3:0]   rkAddr = '0;

    logic         keyReadyR, busyR, validR, rkVR;
    logic [127:0] rkR;
    logic         keyReadyC, busyC, validC, rkVC;
    logic [127:0] rkC;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sboxTab [256];
    logic [127:0] expRk [15];

    aes256_key_sched_ctrl #(.read_reg_p(1'b1)) dutReg (
        .clk_i(clk), .reset_i(rst), .key_v_i(keyV), .key_i(keyData),
        .key_ready_o(keyReadyR), .busy_o(busyR), .keys_valid_o(validR),
        .rk_addr_i(rkAddr), .rk_o(rkR), .rk_v_o(rkVR)
    );

    aes256_key_sched_ctrl #(.read_reg_p(1'b0)) dutComb (
        .clk_i(clk), .reset_i(rst), .key_v_i(keyV), .key_i(keyData),
        .key_ready_o(keyReadyC), .busy_o(busyC), .keys_valid_o(validC),
        .rk_addr_i(rkAddr), .rk_o(rkC), .rk_v_o(rkVC)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15 - n -: 8];
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine map.
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subW(input logic [31:0] t);
        return {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
    endfunction

    // Textbook 60-word expansion, sliced into fifteen 128-bit round keys.
    task automatic computeModel(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i - 1];
            if (i % 8 == 0) begin
                rc = 8'(1 << (i / 8 - 1));
                t = subW({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (i % 8 == 4) begin
                t = subW(t);
            end
            w[i] = w[i - 8] ^ t;
        end
        for (int j = 0; j < 15; j++) expRk[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    endtask

    function automatic logic [255:0] randKey();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadKey(input logic [255:0] key);
        keyData = key;
        keyV = 1'b1;
        tick();
        keyV = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (keyReadyR !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", keyReadyR); end
        checks++; if (busyR !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busyR); end
        checks++; if (validR !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", validR); end
        checks++; if (rkR !== 128'h0) begin errors++; $display("[TB] FAIL reset_rk: got %h want 0", rkR); end
        checks++; if (rkVR !== 1'b0) begin errors++; $display("[TB] FAIL reset_rkv: got %b want 0", rkVR); end
        checks++; if (rkVC !== 1'b0) begin errors++; $display("[TB] FAIL reset_rkv_comb: got %b want 0", rkVC); end
        rst = 1'b0;
        tick();
        checks++; if (keyReadyC !== 1'b1 || validC !== 1'b0) begin errors++; $display("[TB] FAIL idle_comb: got ready=%b valid=%b want 1/0", keyReadyC, validC); end
    endtask

    // Read every index from both instances and compare to the model.
    task automatic readAll(input string tag);
        for (int i = 0; i < 15; i++) begin
            rkAddr = 4'(i);
            #1;
            checks++; if (rkC !== expRk[i] || rkVC !== 1'b1) begin errors++; $display("[TB] FAIL %s_comb_rk%0d: got %h v=%b want %h v=1", tag, i, rkC, rkVC, expRk[i]); end
            tick();
            checks++; if (rkR !== expRk[i] || rkVR !== 1'b1) begin errors++; $display("[TB] FAIL %s_reg_rk%0d: got %h v=%b want %h v=1", tag, i, rkR, rkVR, expRk[i]); end
        end
    endtask

    task automatic waitExpansion(input string tag, input int expCycles);
        int n = 0;
        while (validR !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++; if (validR !== 1'b1 || n != expCycles) begin errors++; $display("[TB] FAIL %s_latency: got valid=%b after %0d cycles want valid=1 after %0d", tag, validR, n, expCycles); end
    endtask

    task automatic test_fips();
        computeModel(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        loadKey(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        checks++; if (busyR !== 1'b1 || keyReadyR !== 1'b0) begin errors++; $display("[TB] FAIL fips_busy: got busy=%b ready=%b want 1/0", busyR, keyReadyR); end
        for (int n = 1; n <= 7; n++) begin
            tick();
            checks++; if (validR !== (n == 7) || busyR !== (n != 7)) begin errors++; $display("[TB] FAIL fips_step%0d: got valid=%b busy=%b want %b/%b", n, validR, busyR, n == 7, n != 7); end
        end
        readAll("fips");
        rkAddr = 4'd0; tick();
        checks++; if (rkR !== 128'h000102030405060708090a0b0c0d0e0f) begin errors++; $display("[TB] FAIL fips_rf0: got %h want 000102030405060708090a0b0c0d0e0f", rkR); end
        rkAddr = 4'd2; #1;
        checks++; if (rkC !== 128'ha573c29fa176c498a97fce93a572c09c) begin errors++; $display("[TB] FAIL fips_rf2_comb: got %h want a573c29fa176c498a97fce93a572c09c", rkC); end
        tick();
        checks++; if (rkR !== 128'ha573c29fa176c498a97fce93a572c09c) begin errors++; $display("[TB] FAIL fips_rf2: got %h want a573c29fa176c498a97fce93a572c09c", rkR); end
        rkAddr = 4'd14; tick();
        checks++; if (rkR !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin errors++; $display("[TB] FAIL fips_rf14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", rkR); end
        rkAddr = 4'd15; #1;
        checks++; if (rkC !== 128'h0 || rkVC !== 1'b0) begin errors++; $display("[TB] FAIL addr15_comb: got %h v=%b want 0 v=0", rkC, rkVC); end
        tick();
        checks++; if (rkR !== 128'h0 || rkVR !== 1'b0) begin errors++; $display("[TB] FAIL addr15_reg: got %h v=%b want 0 v=0", rkR, rkVR); end
    endtask

    task automatic test_backpressure();
        logic [255:0] k1 = randKey();
        logic [255:0] k2 = randKey();
        keyData = k1;
        keyV = 1'b1;
        tick();
        keyData = k2;
        for (int n = 1; n <= 7; n++) begin
            rkAddr = 4'($urandom_range(14, 0));
            #1;
            checks++; if (keyReadyR !== 1'b0 || busyR !== 1'b1 || rkVC !== 1'b0) begin errors++; $display("[TB] FAIL bp_expand%0d: got ready=%b busy=%b rkv=%b want 0/1/0", n, keyReadyR, busyR, rkVC); end
            tick();
            checks++; if (rkVR !== 1'b0) begin errors++; $display("[TB] FAIL bp_expand_rkv%0d: got %b want 0", n, rkVR); end
        end
        checks++; if (validR !== 1'b1 || keyReadyR !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got valid=%b ready=%b want 1/1", validR, keyReadyR); end
        tick();
        keyV = 1'b0;
        checks++; if (busyR !== 1'b1 || validR !== 1'b0) begin errors++; $display("[TB] FAIL bp_second_accept: got busy=%b valid=%b want 1/0", busyR, validR); end
        computeModel(k2);
        waitExpansion("bp", 7);
        readAll("bp");
    endtask

    task automatic test_rekey_boundary();
        logic [255:0] k3 = randKey();
        logic [127:0] old5 = expRk[5];
        rkAddr = 4'd5;
        keyData = k3;
        keyV = 1'b1;
        tick();
        keyV = 1'b0;
        checks++; if (rkR !== old5 || rkVR !== 1'b1) begin errors++; $display("[TB] FAIL rekey_old_read: got %h v=%b want %h v=1", rkR, rkVR, old5); end
        tick();
        checks++; if (rkR !== 128'h0 || rkVR !== 1'b0) begin errors++; $display("[TB] FAIL rekey_next_read: got %h v=%b want 0 v=0", rkR, rkVR); end
        computeModel(k3);
        waitExpansion("rekey", 6);
        readAll("rekey");
    endtask

    task automatic test_reset_mid();
        logic [255:0] k5 = randKey();
        rkAddr = 4'd3;
        loadKey(randKey());
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (keyReadyR !== 1'b1 || busyR !== 1'b0 || validR !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got ready=%b busy=%b valid=%b want 1/0/0", keyReadyR, busyR, validR); end
        checks++; if (rkR !== 128'h0 || rkVR !== 1'b0 || rkVC !== 1'b0 || busyC !== 1'b0) begin errors++; $display("[TB] FAIL midrst_read: got rk=%h v=%b vc=%b busyc=%b want 0/0/0/0", rkR, rkVR, rkVC, busyC); end
        #1;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            rkAddr = 4'(i);
            #1;
            checks++; if (rkVC !== 1'b0) begin errors++; $display("[TB] FAIL midrst_gate_comb%0d: got %b want 0", i, rkVC); end
            tick();
            checks++; if (rkVR !== 1'b0) begin errors++; $display("[TB] FAIL midrst_gate_reg%0d: got %b want 0", i, rkVR); end
        end
        computeModel(k5);
        loadKey(k5);
        waitExpansion("midrst", 7);
        readAll("midrst");
    endtask

    // Scenario sequence and summary.
    initial begin
        buildSbox();
        test_reset();
        test_fips();
        test_backpressure();
        test_rekey_boundary();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes256_key_sched_ctrl.md
# aes256_key_sched_ctrl

Sequencer for the AES-256 key expansion. Accepts a 256-bit cipher key over a valid/ready handshake. Iterates the team's combinational expansion step `round_key` (inputs `k`, `r`; output `result`) seven times, one step per clock. Stores the fifteen 128-bit round keys in an internal register file and serves them on a read port to the cipher round datapath.

## Interface
- `read_reg_p`, default 1: 1 = round-key read data registered (1-cycle latency); 0 = combinational read.
- `clk_i` in 1: clock, all state on rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `key_v_i` in 1: cipher key valid.
- `key_i` in 256: cipher key, bit 0 = MSB of the first key byte.
- `key_ready_o` out 1: block can accept a key; high in IDLE and DONE.
- `busy_o` out 1: expansion in progress (EXPAND state).
- `keys_valid_o` out 1: all 15 round keys are valid; high in DONE only.
- `rk_addr_i` in 4: round-key index, 0..14.
- `rk_o` out 128: round key `rk_addr_i`.
- `rk_v_o` out 1: `rk_o` is valid.

## Operation
- Storage:
  - `W`: 256-bit working key.
  - `rnd`: 3-bit step counter.
  - `rf[0..14]`: 128-bit register file (contents not reset).
- **IDLE**
  - Reset state. `key_ready_o` = 1.
  - On accept (`key_v_i & key_ready_o`):
    - `W` <= `key_i`.
    - `rf[0]` <= `key_i[0:127]`; `rf[1]` <= `key_i[128:255]`.
    - `rnd` <= 1.
    - Go to EXPAND.
- **EXPAND**
  - Each cycle: `res` = `round_key(k=W, r={1'b0,rnd})`.
  - Writes: `rf[2*rnd]` <= `res[0:127]`. If `rnd` < 7, also `rf[2*rnd+1]` <= `res[128:255]`. Upper half of step 7 is discarded.
  - `W` <= `res`; `rnd` <= `rnd`+1.
  - After the `rnd`=7 step, go to DONE.
  - `key_ready_o` = 0: keys offered here are not accepted and must be held by the source.
- **DONE**
  - `keys_valid_o` = 1, `key_ready_o` = 1.
  - An accept behaves as in IDLE and returns to EXPAND. `keys_valid_o` is 0 from the next cycle.
- **Read port**
  - Index is in range when `rk_addr_i` <= 14. A read is valid when the index is in range and `keys_valid_o` = 1.
  - `read_reg_p`=1: `rk_o` <= valid ? `rf[rk_addr_i]` : 0; `rk_v_o` <= valid.
  - `read_reg_p`=0: same expressions, combinational.
  - Out of range (15) or not `keys_valid_o`: `rk_o` = 0, `rk_v_o` = 0. No error state.
- **Widths**
  - `rnd` never exceeds 7. Value passed to `r` is 1..7, so rcon stays within 0x01000000..0x40000000.
  - Counter wrap is impossible by construction.

## Timing
- Reset values:
  - State = IDLE; `key_ready_o`=1, `busy_o`=0, `keys_valid_o`=0.
  - `rk_o`=0, `rk_v_o`=0 (registered variant).
  - `W`=0, `rnd`=0.
- Latency:
  - Accept at edge T0; EXPAND steps at edges T1..T7.
  - `busy_o` is high during the cycles after T0 through T7.
  - `keys_valid_o` is high from the cycle after T7, i.e. 7 cycles after the accept cycle.
- Read timing:
  - With `read_reg_p`=1, data for the address presented before edge Tn appears after Tn.
  - First valid registered read: address presented in the first DONE cycle, data in the next cycle.
- Re-key while serving:
  - Accept in DONE at edge T0. A read sampled at T0 still returns old `rf` contents with `rk_v_o`=1, because the register-file writes at T0 land after the read sample.
  - From the cycle after T0, `rk_v_o`=0.
- Reset mid-EXPAND:
  - Immediate return to IDLE; outputs take reset values asynchronously.
  - Partial `rf` contents are never reported valid.
- Simultaneous events:
  - `key_v_i` with a read in DONE: both honoured as above.
  - `key_v_i` during EXPAND: ignored.

## Test plan
- **FIPS-197 key** 000102…1f, then read all indices in DONE:
  - `rf[0]`=000102030405060708090a0b0c0d0e0f.
  - `rf[2]`=a573c29fa176c498a97fce93a572c09c.
  - `rf[14]`=24fc79ccbf0979e9371ac23c6d68de36.
  - `keys_valid_o` rises exactly 7 cycles after the accept cycle.
- **Backpressure**: hold `key_v_i`=1 with a second key during EXPAND.
  - `key_ready_o`=0 throughout; the second key is accepted in the first DONE cycle.
  - The second expansion completes 7 cycles later.
- **Reset mid-expansion**: assert `reset_i` at step 4.
  - All outputs return to reset values without waiting for a clock edge.
  - `rk_v_o`=0 for every address until a new key completes.
- **Read gating**:
  - `rk_addr_i`=15 in DONE gives `rk_o`=0, `rk_v_o`=0.
  - Any address during EXPAND gives `rk_v_o`=0.
- **Re-key boundary**: read index 5 in the same cycle a new key is accepted in DONE.
  - Returns the old key's `rf[5]` with `rk_v_o`=1.
  - The next-cycle read gives `rk_v_o`=0.
- **Combinational read variant**: repeat the FIPS test with `read_reg_p`=0.
  - `rk_o` follows `rk_addr_i` in the same cycle.
